// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcodes, ALU latency and response entry layout.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MAX = 4'd4;

    // Register stages inside the ALU between operand input and result output
    localparam int ALU_LAT = 3;

    // Default tag width carried alongside each command
    localparam int RSP_TAG_W = 4;

    typedef struct packed {
        logic [15:0]          data;
        logic [RSP_TAG_W-1:0] tag;
        logic                 illegal;
    } rsp_entry_t;

    // Opcodes above OP_MAX are still issued but flagged in the response
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// First-word-fall-through response FIFO with registered head and occupancy output.
module rsp_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [PW-1:0]    occ;
    logic [PW-1:0]    occ_next;
    logic             push;
    logic             pop;

    // Pointer update, storage write and next head selection; the head is kept
    // in its own register so it holds its last value while the FIFO is empty
    always_comb begin
        occ      = wr_ptr_q - rd_ptr_q;
        pop      = rd_en && (occ != '0);
        push     = wr_en && ((occ != PW'(DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_next = wr_ptr_d - rd_ptr_d;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        end
        head_d = head_q;
        if (occ_next != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Pointers and head register, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // Entry storage needs no reset since the pointers define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_valid = (occ != '0);
    assign rd_data  = head_q;
    assign count    = occ;

endmodule

// File: rtl/alu_issue_collect.sv
// Issues commands to the pipelined ALU, tracks them through its latency and
// collects results into a credit-protected response FIFO.
module alu_issue_collect #(
    parameter int ALU_LAT = alu_pkg::ALU_LAT,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = alu_pkg::RSP_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [15:0]            cmd_a,
    input  logic [15:0]            cmd_b,
    input  logic [3:0]             cmd_op,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic [15:0]            alu_a,
    output logic [15:0]            alu_b,
    output logic [3:0]             alu_op,
    input  logic [15:0]            alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_illegal,
    output logic [$clog2(DEPTH):0] inflight
);

    import alu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 16 + TAG_W + 1;

    logic [15:0]                alu_a_q, alu_a_d;
    logic [15:0]                alu_b_q, alu_b_d;
    logic [3:0]                 alu_op_q, alu_op_d;
    logic [ALU_LAT:0]           trk_vld_q, trk_vld_d;
    logic [ALU_LAT:0][TAG_W-1:0] trk_tag_q, trk_tag_d;
    logic [ALU_LAT:0]           trk_ill_q, trk_ill_d;
    logic                       run_q, run_d;
    logic [CNT_W-1:0]           inflight_cnt;
    logic [CNT_W-1:0]           fifo_count;
    logic [CNT_W:0]             credit_used;
    logic                       accept;
    logic                       fifo_wr_en;
    logic [ENT_W-1:0]           fifo_wr_data;
    logic [ENT_W-1:0]           fifo_rd_data;
    logic                       fifo_rd_valid;

    // Credit check from registered state only: in-flight ops plus buffered
    // results must leave room so the never-stalling pipe always has a slot
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(trk_vld_q[i]);
        end
        credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_count};
        cmd_ready   = run_q && (int'(credit_used) < DEPTH);
        accept      = cmd_valid && cmd_ready;
    end

    // Operand registers load on a handshake and zero otherwise; the tracking
    // pipe shifts every cycle with a bubble entered when nothing is accepted
    always_comb begin
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_op_d  = '0;
        run_d     = 1'b1;
        trk_vld_d = {trk_vld_q[ALU_LAT-1:0], accept};
        trk_ill_d = {trk_ill_q[ALU_LAT-1:0], accept && is_illegal_op(cmd_op)};
        trk_tag_d = '0;
        for (int i = 1; i <= ALU_LAT; i++) begin
            trk_tag_d[i] = trk_tag_q[i-1];
        end
        if (accept) begin
            alu_a_d      = cmd_a;
            alu_b_d      = cmd_b;
            alu_op_d     = cmd_op;
            trk_tag_d[0] = cmd_tag;
        end
    end

    // Issue and tracking state; run_q keeps cmd_ready low while in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            trk_vld_q <= '0;
            trk_tag_q <= '0;
            trk_ill_q <= '0;
            run_q     <= 1'b0;
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            trk_vld_q <= trk_vld_d;
            trk_tag_q <= trk_tag_d;
            trk_ill_q <= trk_ill_d;
            run_q     <= run_d;
        end
    end

    assign fifo_wr_en   = trk_vld_q[ALU_LAT];
    assign fifo_wr_data = {alu_result, trk_tag_q[ALU_LAT], trk_ill_q[ALU_LAT]};

    rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_wr_en),
        .wr_data  (fifo_wr_data),
        .rd_en    (rsp_ready),
        .rd_valid (fifo_rd_valid),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = fifo_rd_valid;
    assign rsp_data    = fifo_rd_data[ENT_W-1 -: 16];
    assign rsp_tag     = fifo_rd_data[TAG_W:1];
    assign rsp_illegal = fifo_rd_data[0];
    assign inflight    = inflight_cnt;

endmodule

// File: tb/tb_alu_issue_collect.sv
// Directed bench for alu_issue_collect with a 3-stage behavioural ALU attached.
module tb_alu_issue_collect;

    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_a;
    logic [15:0]       cmd_b;
    logic [3:0]        cmd_op;
    logic [TAG_W-1:0]  cmd_tag;
    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [3:0]        alu_op;
    logic [15:0]       alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_illegal;
    logic [3:0]        inflight;

    int n_vectors = 0;
    int n_miscompares = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [15:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [20];

    alu_issue_collect #(
        .ALU_LAT (3),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_tag     (cmd_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_tag     (rsp_tag),
        .rsp_illegal (rsp_illegal),
        .inflight    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the 3-stage ALU, reset on the same net as the DUT
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] alu_s1, alu_s2, alu_s3;

    // Three register stages between operand input and result output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_s1 <= '0;
            alu_s2 <= '0;
            alu_s3 <= '0;
        end else begin
            alu_s1 <= alu_fn(alu_a, alu_b, alu_op);
            alu_s2 <= alu_s1;
            alu_s3 <= alu_s2;
        end
    end

    assign alu_result = alu_s3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] op, input logic [3:0] tag);
        cmd_valid = valid;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drain everything and wait for credits to return, bounded
    task automatic waitIdle();
        int cyc;
        cyc = 0;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        rsp_ready = 1'b1;
        while (!(rsp_valid == 1'b0 && inflight == 4'd0 && cmd_ready == 1'b1) && cyc < 60) begin
            tick();
            cyc++;
        end
        checkOutput("idle_reached", 32'(cyc < 60), 32'd1);
    endtask

    // One op from idle with rsp_ready high: visible 4 edges after acceptance, held one cycle
    task automatic runSingle(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                             input logic [3:0] tag, input logic [15:0] exp_data, input logic exp_ill);
        rsp_ready = 1'b1;
        checkOutput("single_cmd_ready", cmd_ready, 1);
        applyStimulus(1'b1, a, b, op, tag);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        checkOutput("single_alu_a", alu_a, a);
        checkOutput("single_alu_b", alu_b, b);
        checkOutput("single_alu_op", alu_op, op);
        checkOutput("single_inflight", inflight, 1);
        for (int c = 1; c <= 4; c++) begin
            checkOutput("single_early_valid", rsp_valid, 0);
            tick();
        end
        checkOutput("single_rsp_valid", rsp_valid, 1);
        checkOutput("single_rsp_data", rsp_data, exp_data);
        checkOutput("single_rsp_tag", rsp_tag, tag);
        checkOutput("single_rsp_illegal", rsp_illegal, exp_ill);
        tick();
        checkOutput("single_rsp_gone", rsp_valid, 0);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int peak;
        int acc;

        vecs[0]  = '{16'h0003, 16'h0004, OP_ADD, 4'd0,  16'h0007, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, OP_SUB, 4'd1,  16'hFFFF, 1'b0};
        vecs[2]  = '{16'hF0F0, 16'hFF00, OP_AND, 4'd2,  16'hF000, 1'b0};
        vecs[3]  = '{16'hF0F0, 16'h0F0F, OP_OR,  4'd3,  16'hFFFF, 1'b0};
        vecs[4]  = '{16'hAAAA, 16'h5555, OP_XOR, 4'd4,  16'hFFFF, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'h0001, OP_ADD, 4'd5,  16'h0000, 1'b0};
        vecs[6]  = '{16'h1000, 16'h0001, OP_SUB, 4'd6,  16'h0FFF, 1'b0};
        vecs[7]  = '{16'h1234, 16'h00FF, OP_AND, 4'd7,  16'h0034, 1'b0};
        vecs[8]  = '{16'h1200, 16'h0034, OP_OR,  4'd8,  16'h1234, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'h1234, OP_XOR, 4'd9,  16'hEDCB, 1'b0};
        vecs[10] = '{16'h1234, 16'h4321, OP_ADD, 4'd10, 16'h5555, 1'b0};
        vecs[11] = '{16'h0005, 16'h0007, OP_SUB, 4'd11, 16'hFFFE, 1'b0};
        vecs[12] = '{16'h1234, 16'h0001, 4'd9,   4'd12, 16'h0000, 1'b1};
        vecs[13] = '{16'h7FFF, 16'h0001, OP_ADD, 4'd13, 16'h8000, 1'b0};
        vecs[14] = '{16'hAAAA, 16'h5555, OP_AND, 4'd14, 16'h0000, 1'b0};
        vecs[15] = '{16'h0000, 16'h0000, OP_OR,  4'd15, 16'h0000, 1'b0};
        vecs[16] = '{16'h0F0F, 16'h00FF, OP_XOR, 4'd0,  16'h0FF0, 1'b0};
        vecs[17] = '{16'h8000, 16'h0001, OP_SUB, 4'd1,  16'h7FFF, 1'b0};
        vecs[18] = '{16'h00FF, 16'h0001, OP_ADD, 4'd2,  16'h0100, 1'b0};
        vecs[19] = '{16'h8000, 16'h0001, OP_OR,  4'd3,  16'h8001, 1'b0};

        // Reset state
        reset     = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        tick();
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_inflight", inflight, 0);
        checkOutput("reset_alu_op", alu_op, 0);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_cmd_ready", cmd_ready, 1);

        // Single ADD
        runSingle(16'h0003, 16'h0004, OP_ADD, 4'd5, 16'h0007, 1'b0);
        waitIdle();

        // Back-to-back stream from the vector table
        rsp_ready = 1'b1;
        peak = 0;
        for (int c = 0; c < 26; c++) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            if (c < 20) checkOutput("stream_cmd_ready", cmd_ready, 1);
            checkOutput("stream_rsp_valid", rsp_valid, 32'(c >= 5 && c < 25));
            if (c >= 5 && c < 25) begin
                checkOutput("stream_rsp_data", rsp_data, vecs[c-5].exp_data);
                checkOutput("stream_rsp_tag", rsp_tag, vecs[c-5].tag);
                checkOutput("stream_rsp_illegal", rsp_illegal, vecs[c-5].exp_ill);
            end
            if (c < 20) applyStimulus(1'b1, vecs[c].a, vecs[c].b, vecs[c].op, vecs[c].tag);
            else        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
            tick();
        end
        checkOutput("stream_inflight_peak", peak, 4);
        waitIdle();

        // Backpressure: fill all credits, then drain
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 16'(acc), 16'h0100, OP_ADD, 4'(acc));
            if (cmd_ready) acc++;
            tick();
        end
        checkOutput("bp_accepted", acc, 8);
        checkOutput("bp_cmd_ready_low", cmd_ready, 0);
        checkOutput("bp_inflight_zero", inflight, 0);
        checkOutput("bp_head_valid", rsp_valid, 1);
        checkOutput("bp_head_data", rsp_data, 16'h0100);
        applyStimulus(1'b1, 16'h0000, 16'h0200, OP_OR, 4'hA);
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_ready_after_pop", cmd_ready, 1);
        checkOutput("bp_head1_data", rsp_data, 16'h0101);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        for (int j = 2; j < 8; j++) begin
            checkOutput("bp_drain_valid", rsp_valid, 1);
            checkOutput("bp_drain_data", rsp_data, 16'h0100 + 16'(j));
            checkOutput("bp_drain_tag", rsp_tag, 4'(j));
            tick();
        end
        checkOutput("bp_new_valid", rsp_valid, 1);
        checkOutput("bp_new_data", rsp_data, 16'h0200);
        checkOutput("bp_new_tag", rsp_tag, 4'hA);
        tick();
        checkOutput("bp_empty", rsp_valid, 0);
        waitIdle();

        // FIFO at 7 with one op in flight, pop on the cycle of its write
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checkOutput("sp_cmd_ready", cmd_ready, 1);
            applyStimulus(1'b1, 16'h2000, 16'(c), OP_ADD, 4'(c));
            tick();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        tick();
        tick();
        checkOutput("sp_inflight_one", inflight, 1);
        checkOutput("sp_cmd_ready_low", cmd_ready, 0);
        checkOutput("sp_head_data", rsp_data, 16'h2000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("sp_inflight_zero", inflight, 0);
        checkOutput("sp_cmd_ready_back", cmd_ready, 1);
        rsp_ready = 1'b1;
        for (int j = 1; j < 8; j++) begin
            checkOutput("sp_drain_valid", rsp_valid, 1);
            checkOutput("sp_drain_data", rsp_data, 16'h2000 + 16'(j));
            checkOutput("sp_drain_tag", rsp_tag, 4'(j));
            tick();
        end
        checkOutput("sp_empty", rsp_valid, 0);
        checkOutput("sp_hold_data", rsp_data, 16'h2007);
        waitIdle();

        // Reset with three ops in flight
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 16'h1111, 16'h2222, OP_ADD, 4'd1);
        tick();
        applyStimulus(1'b1, 16'h3333, 16'h0001, OP_SUB, 4'd2);
        tick();
        applyStimulus(1'b1, 16'h00F0, 16'h0F00, OP_OR, 4'd3);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        checkOutput("rst_pre_inflight", inflight, 3);
        checkOutput("rst_pre_alu_a", alu_a, 16'h00F0);
        reset = 1'b1;
        #1;
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_tag", rsp_tag, 0);
        checkOutput("rst_rsp_illegal", rsp_illegal, 0);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checkOutput("rst_after_valid", rsp_valid, 0);
            tick();
        end
        waitIdle();

        // Illegal opcode
        runSingle(16'h1234, 16'h0001, 4'd9, 4'd3, 16'h0000, 1'b1);
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
